// File: rtl/rom_stream_reader_if.sv
// Downstream stream interface of rom_stream_reader.
// The master drives valid/data/last; the slave answers with ready.
// A word transfers on any rising edge where m_valid && m_ready.
interface rom_stream_reader_if #(
  parameter int DATA_W = 4
) ();

  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              m_ready;

  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );

endinterface : rom_stream_reader_if

// File: rtl/rom_stream_reader.sv
// Read-side sequencer for lookup ROMs.
// A start command sweeps base..base+len-1 (wrapping) of a synchronous-read
// ROM. Returned words are tracked through a latency tag pipeline, buffered
// in a small first-word-fall-through FIFO and streamed out over valid/ready
// with the final word flagged. Reads are only issued while buffer credit
// remains, so the FIFO can never overflow regardless of consumer stalls.
module rom_stream_reader #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 4,
  parameter int LEN_W      = 8,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // control side
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [LEN_W-1:0]     len,
  output logic                 busy,
  output logic                 done,
  // ROM side
  output logic [ADDR_W-1:0]    rom_addr,
  output logic                 rom_rd_en,
  input  logic [DATA_W-1:0]    rom_data,
  // stream side
  rom_stream_reader_if.master  m_if
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  // Wide enough to hold FIFO occupancy plus every read that can be in flight.
  localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_FINISH
  } state_e;

  // ---------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------
  state_e              state_q, state_d;
  logic                rd_en_q, rd_en_d;        // read strobe presented to the ROM
  logic                rd_last_q, rd_last_d;    // current read is the burst's final one
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    rem_q, rem_d;            // reads still to issue after the current one

  logic [RD_LAT-1:0]   tag_v_q;                 // valid tag per latency stage
  logic [RD_LAT-1:0]   tag_l_q;                 // last flag per latency stage

  logic [DATA_W:0]     mem_q [FIFO_DEPTH];      // {last, data}
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]      count_q;

  logic                tag_exit_v;
  logic                tag_exit_l;
  logic                fifo_empty;
  logic                head_valid;
  logic [DATA_W:0]     head_word;
  logic                push;
  logic                pop;
  logic                store;
  logic                take;
  logic [CNT_W-1:0]    tag_cnt;
  logic [CNT_W-1:0]    outstanding;
  logic                credit;

  // ---------------------------------------------------------------------
  // Datapath decode: tag exit, FIFO head with fall-through, credit
  // ---------------------------------------------------------------------
  assign tag_exit_v = tag_v_q[RD_LAT-1];
  assign tag_exit_l = tag_l_q[RD_LAT-1];
  assign fifo_empty = (count_q == '0);

  // When the FIFO is empty the arriving ROM word is presented directly, so a
  // word reaches the consumer in the same cycle it leaves the ROM.
  assign head_valid = !fifo_empty || tag_exit_v;
  assign head_word  = fifo_empty ? {tag_exit_l, rom_data} : mem_q[rd_ptr_q];

  assign push  = tag_exit_v;
  assign pop   = head_valid && m_if.m_ready;
  // A pop from an empty FIFO consumes the bypassed word, which then is never stored.
  assign store = push && !(pop && fifo_empty);
  assign take  = pop && !fifo_empty;

  assign m_if.m_valid = head_valid;
  assign m_if.m_data  = head_valid ? head_word[DATA_W-1:0] : '0;
  assign m_if.m_last  = head_valid ? head_word[DATA_W]     : 1'b0;

  // Count every read that will eventually claim a FIFO slot.
  // NOTE: always_comb uses blocking '=' so the running sum is visible to the
  // next statement; clocked blocks use '<=' so all registers update together.
  always_comb begin
    tag_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      tag_cnt = tag_cnt + CNT_W'(tag_v_q[i]);
    end
    outstanding = CNT_W'(count_q) + CNT_W'(rd_en_q) + tag_cnt;
    // A pop this cycle frees a slot before the next read could land.
    credit = (outstanding - CNT_W'(pop)) < CNT_W'(FIFO_DEPTH);
  end

  // ---------------------------------------------------------------------
  // Sequencer: next-state, read issue and burst bookkeeping
  // ---------------------------------------------------------------------
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d   = state_q;
    rd_en_d   = 1'b0;
    rd_last_d = 1'b0;
    addr_d    = addr_q;
    rem_d     = rem_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            // The FIFO and pipeline are empty in IDLE, so the first read
            // always has credit and issues immediately.
            state_d   = S_ISSUE;
            rd_en_d   = 1'b1;
            rd_last_d = (len == LEN_W'(1));
            addr_d    = base_addr;
            rem_d     = len - LEN_W'(1);
          end else begin
            state_d = S_FINISH;
          end
        end
      end

      S_ISSUE: begin
        if (rem_q == '0) begin
          // The final read is on the bus this cycle; wait for its word.
          state_d = S_DRAIN;
        end else if (credit) begin
          rd_en_d   = 1'b1;
          rd_last_d = (rem_q == LEN_W'(1));
          addr_d    = addr_q + ADDR_W'(1);
          rem_d     = rem_q - LEN_W'(1);
        end
      end

      S_DRAIN: begin
        if (pop && head_word[DATA_W]) begin
          state_d = S_FINISH;
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered ROM interface
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rd_en_q   <= 1'b0;
      rd_last_q <= 1'b0;
      addr_q    <= '0;
      rem_q     <= '0;
    end else begin
      state_q   <= state_d;
      rd_en_q   <= rd_en_d;
      rd_last_q <= rd_last_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
    end
  end

  assign rom_rd_en = rd_en_q;
  assign rom_addr  = addr_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FINISH);

  // ---------------------------------------------------------------------
  // Latency tag pipeline: a tag reaches the last stage in the cycle its
  // ROM word is valid on rom_data.
  // ---------------------------------------------------------------------
  // Shift {valid,last} tags alongside the ROM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v_q <= '0;
      tag_l_q <= '0;
    end else begin
      tag_v_q[0] <= rd_en_q;
      tag_l_q[0] <= rd_en_q && rd_last_q;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_l_q[i] <= tag_l_q[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------
  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (store) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (take) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      unique case ({store, take})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage
  // NOTE: the storage array has no reset; occupancy is reset and the output
  // is gated by m_valid, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (store) begin
      mem_q[wr_ptr_q] <= {tag_exit_l, rom_data};
    end
  end

  // ---------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------
  // Credit accounting keeps the FIFO from ever receiving a word when full.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count_q == FULL_CNT)));

  // A stalled output word must not change underneath the consumer.
  assert property (@(posedge clk) disable iff (!rst_n)
    (m_if.m_valid && !m_if.m_ready) |=>
      (m_if.m_valid && $stable(m_if.m_data) && $stable(m_if.m_last)));

endmodule : rom_stream_reader

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader with an RD_LAT=1 ROM holding
// data = (2*addr) % 16. Each scenario task drives a burst and compares the
// recorded ROM reads, stream handshakes and done/busy timing against
// hand-computed values. Cycle 1 is the first cycle after start is sampled.
module tb_rom_stream_reader;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 4;
  localparam int LEN_W      = 8;
  localparam int RD_LAT     = 1;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_rd_en;
  logic [DATA_W-1:0] rom_data = '0;

  rom_stream_reader_if #(.DATA_W(DATA_W)) m_if ();

  rom_stream_reader #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .LEN_W     (LEN_W),
    .RD_LAT    (RD_LAT),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .rom_addr (rom_addr),
    .rom_rd_en(rom_rd_en),
    .rom_data (rom_data),
    .m_if     (m_if)
  );

  always #5 clk = ~clk;

  // Synchronous ROM, one cycle of read latency.
  always @(posedge clk) begin
    if (rom_rd_en) rom_data <= {rom_addr[2:0], 1'b0};
  end

  int n_pass  = 0;
  int n_total = 0;

  // Per-burst observation record
  int hs_data[$];
  int hs_last[$];
  int hs_cyc[$];
  int rd_addr[$];
  int rd_cyc[$];
  int done_cyc[$];
  int busy_cyc[$];
  int stall_err;
  int peak_out;
  int timed_out;

  // Drive one burst and record everything until two cycles after done.
  // ready_mode 0: m_ready always 1; 1: m_ready pattern 1,0,0 repeating.
  // extra_cyc >= 1 pulses a second start (base extra_b, len 3) in that cycle.
  task automatic run_burst(input int b, input int l, input int ready_mode,
                           input int extra_cyc, input int extra_b);
    int   cyc;
    int   after;
    int   issued;
    int   popped;
    logic pv;
    logic [DATA_W-1:0] pd;
    logic pl;
    hs_data.delete(); hs_last.delete(); hs_cyc.delete();
    rd_addr.delete(); rd_cyc.delete(); done_cyc.delete(); busy_cyc.delete();
    stall_err = 0; peak_out = 0; timed_out = 0;
    cyc = 0; after = -1; issued = 0; popped = 0; pv = 1'b0; pd = '0; pl = 1'b0;
    @(negedge clk);
    start = 1'b1; base_addr = 8'(b); len = 8'(l); m_if.m_ready = 1'b1;
    while (cyc != after && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == extra_cyc) begin
        start = 1'b1; base_addr = 8'(extra_b); len = 8'd3;
      end else begin
        start = 1'b0; base_addr = 8'(b); len = 8'(l);
      end
      m_if.m_ready = (ready_mode == 0) ? 1'b1 : (((cyc - 1) % 3) == 0);
      #1;
      if (rom_rd_en) begin
        issued++;
        rd_addr.push_back(int'(rom_addr));
        rd_cyc.push_back(cyc);
      end
      if (issued - popped > peak_out) peak_out = issued - popped;
      if (pv && (!m_if.m_valid || m_if.m_data !== pd || m_if.m_last !== pl)) stall_err++;
      pv = m_if.m_valid && !m_if.m_ready;
      pd = m_if.m_data;
      pl = m_if.m_last;
      if (m_if.m_valid && m_if.m_ready) begin
        hs_data.push_back(int'(m_if.m_data));
        hs_last.push_back(int'(m_if.m_last));
        hs_cyc.push_back(cyc);
        popped++;
      end
      if (busy) busy_cyc.push_back(cyc);
      if (done) begin
        done_cyc.push_back(cyc);
        if (after < 0) after = cyc + 2;
      end
    end
    if (cyc != after) timed_out = 1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; m_if.m_ready = 1'b0;
    @(negedge clk);
    n_total++;
    if ({busy, done, rom_rd_en, rom_addr, m_if.m_valid, m_if.m_data, m_if.m_last} !== 17'd0)
      $display("FAIL reset_outputs: got %h expected 0",
               {busy, done, rom_rd_en, rom_addr, m_if.m_valid, m_if.m_data, m_if.m_last});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_speed();
    run_burst(0, 8, 0, -1, 0);
    n_total++;
    if (timed_out !== 0) $display("FAIL full_timeout: got %0d expected 0", timed_out); else n_pass++;
    n_total++;
    if (rd_cyc.size() !== 8) $display("FAIL full_reads: got %0d expected 8", rd_cyc.size()); else n_pass++;
    if (rd_cyc.size() == 8)
      for (int i = 0; i < 8; i++) begin
        n_total++;
        if (rd_addr[i] !== i || rd_cyc[i] !== i + 1)
          $display("FAIL full_rd%0d: got addr %0d cyc %0d expected addr %0d cyc %0d",
                   i, rd_addr[i], rd_cyc[i], i, i + 1);
        else n_pass++;
      end
    n_total++;
    if (hs_data.size() !== 8) $display("FAIL full_words: got %0d expected 8", hs_data.size()); else n_pass++;
    if (hs_data.size() == 8)
      for (int i = 0; i < 8; i++) begin
        n_total++;
        if (hs_data[i] !== 2 * i || hs_cyc[i] !== i + 2 || hs_last[i] !== int'(i == 7))
          $display("FAIL full_word%0d: got data %0d cyc %0d last %0d expected %0d %0d %0d",
                   i, hs_data[i], hs_cyc[i], hs_last[i], 2 * i, i + 2, int'(i == 7));
        else n_pass++;
      end
    n_total++;
    if (done_cyc.size() !== 1 || done_cyc[0] !== 10)
      $display("FAIL full_done: got count %0d first %0d expected 1 at 10",
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
    else n_pass++;
    n_total++;
    if (busy_cyc.size() !== 10 || busy_cyc[0] !== 1 || busy_cyc[busy_cyc.size()-1] !== 10)
      $display("FAIL full_busy: got %0d cycles expected cycles 1-10", busy_cyc.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    run_burst(0, 8, 1, -1, 0);
    n_total++;
    if (timed_out !== 0) $display("FAIL bp_timeout: got %0d expected 0", timed_out); else n_pass++;
    n_total++;
    if (rd_addr.size() !== 8) $display("FAIL bp_reads: got %0d expected 8", rd_addr.size()); else n_pass++;
    if (rd_addr.size() == 8)
      for (int i = 0; i < 8; i++) begin
        n_total++;
        if (rd_addr[i] !== i) $display("FAIL bp_rd%0d: got %0d expected %0d", i, rd_addr[i], i);
        else n_pass++;
      end
    n_total++;
    if (hs_data.size() !== 8) $display("FAIL bp_words: got %0d expected 8", hs_data.size()); else n_pass++;
    if (hs_data.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        n_total++;
        if (hs_data[i] !== 2 * i || hs_last[i] !== int'(i == 7))
          $display("FAIL bp_word%0d: got data %0d last %0d expected %0d %0d",
                   i, hs_data[i], hs_last[i], 2 * i, int'(i == 7));
        else n_pass++;
      end
      n_total++;
      if (done_cyc.size() !== 1 || done_cyc[0] !== hs_cyc[7] + 1)
        $display("FAIL bp_done: got count %0d expected 1 at %0d", done_cyc.size(), hs_cyc[7] + 1);
      else n_pass++;
    end
    n_total++;
    if (stall_err !== 0) $display("FAIL bp_stable: got %0d changes expected 0", stall_err); else n_pass++;
    n_total++;
    if (peak_out !== FIFO_DEPTH)
      $display("FAIL bp_credit: got peak %0d expected %0d", peak_out, FIFO_DEPTH);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int exp_addr[4] = '{254, 255, 0, 1};
    int exp_data[4] = '{12, 14, 0, 2};
    run_burst(254, 4, 0, -1, 0);
    n_total++;
    if (rd_addr.size() !== 4 || hs_data.size() !== 4 || timed_out !== 0)
      $display("FAIL wrap_counts: got reads %0d words %0d timeout %0d expected 4 4 0",
               rd_addr.size(), hs_data.size(), timed_out);
    else n_pass++;
    if (rd_addr.size() == 4 && hs_data.size() == 4)
      for (int i = 0; i < 4; i++) begin
        n_total++;
        if (rd_addr[i] !== exp_addr[i] || hs_data[i] !== exp_data[i] || hs_last[i] !== int'(i == 3))
          $display("FAIL wrap_%0d: got addr %0d data %0d last %0d expected %0d %0d %0d",
                   i, rd_addr[i], hs_data[i], hs_last[i], exp_addr[i], exp_data[i], int'(i == 3));
        else n_pass++;
      end
    n_total++;
    if (done_cyc.size() !== 1 || done_cyc[0] !== 6)
      $display("FAIL wrap_done: got count %0d expected 1 at 6", done_cyc.size());
    else n_pass++;
  endtask

  task automatic test_empty_burst();
    run_burst(0, 0, 0, -1, 0);
    n_total++;
    if (rd_addr.size() !== 0 || hs_data.size() !== 0)
      $display("FAIL empty_traffic: got reads %0d words %0d expected 0 0", rd_addr.size(), hs_data.size());
    else n_pass++;
    n_total++;
    if (done_cyc.size() !== 1 || done_cyc[0] !== 1)
      $display("FAIL empty_done: got count %0d expected 1 at 1", done_cyc.size());
    else n_pass++;
    n_total++;
    if (busy_cyc.size() !== 1 || busy_cyc[0] !== 1)
      $display("FAIL empty_busy: got %0d cycles expected only cycle 1", busy_cyc.size());
    else n_pass++;
  endtask

  task automatic test_ignored_start();
    run_burst(0, 8, 0, 3, 100);
    n_total++;
    if (rd_addr.size() !== 8 || hs_data.size() !== 8)
      $display("FAIL ign_counts: got reads %0d words %0d expected 8 8", rd_addr.size(), hs_data.size());
    else n_pass++;
    if (rd_addr.size() == 8 && hs_data.size() == 8)
      for (int i = 0; i < 8; i++) begin
        n_total++;
        if (rd_addr[i] !== i || hs_data[i] !== 2 * i || hs_last[i] !== int'(i == 7))
          $display("FAIL ign_%0d: got addr %0d data %0d last %0d expected %0d %0d %0d",
                   i, rd_addr[i], hs_data[i], hs_last[i], i, 2 * i, int'(i == 7));
        else n_pass++;
      end
    n_total++;
    if (done_cyc.size() !== 1 || done_cyc[0] !== 10)
      $display("FAIL ign_done: got count %0d expected 1 at 10", done_cyc.size());
    else n_pass++;
    // A start after done is honoured.
    run_burst(100, 2, 0, -1, 0);
    n_total++;
    if (rd_addr.size() !== 2 || hs_data.size() !== 2)
      $display("FAIL after_counts: got reads %0d words %0d expected 2 2", rd_addr.size(), hs_data.size());
    else n_pass++;
    if (rd_addr.size() == 2 && hs_data.size() == 2) begin
      n_total++;
      if (rd_addr[0] !== 100 || rd_addr[1] !== 101 || hs_data[0] !== 8 || hs_data[1] !== 10 ||
          hs_last[0] !== 0 || hs_last[1] !== 1)
        $display("FAIL after_words: got addr %0d,%0d data %0d,%0d last %0d,%0d expected 100,101 8,10 0,1",
                 rd_addr[0], rd_addr[1], hs_data[0], hs_data[1], hs_last[0], hs_last[1]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_burst();
    int words;
    int bad;
    words = 0; bad = 0;
    @(negedge clk);
    start = 1'b1; base_addr = 8'd0; len = 8'd8; m_if.m_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (m_if.m_valid && m_if.m_ready) words++;
    end
    n_total++;
    if (words !== 3) $display("FAIL rst_pre_words: got %0d expected 3", words); else n_pass++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({busy, done, rom_rd_en, rom_addr, m_if.m_valid, m_if.m_data, m_if.m_last} !== 17'd0)
      $display("FAIL rst_async: got %h expected 0",
               {busy, done, rom_rd_en, rom_addr, m_if.m_valid, m_if.m_data, m_if.m_last});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      if (m_if.m_valid || rom_rd_en || done || busy) bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL rst_stale: got %0d active cycles expected 0", bad); else n_pass++;
    run_burst(0, 2, 0, -1, 0);
    n_total++;
    if (hs_data.size() !== 2 || rd_addr.size() !== 2)
      $display("FAIL rst_fresh_counts: got words %0d reads %0d expected 2 2", hs_data.size(), rd_addr.size());
    else n_pass++;
    if (hs_data.size() == 2) begin
      n_total++;
      if (hs_data[0] !== 0 || hs_data[1] !== 2 || hs_last[0] !== 0 || hs_last[1] !== 1 ||
          hs_cyc[0] !== 2 || hs_cyc[1] !== 3)
        $display("FAIL rst_fresh_words: got data %0d,%0d last %0d,%0d cyc %0d,%0d expected 0,2 0,1 2,3",
                 hs_data[0], hs_data[1], hs_last[0], hs_last[1], hs_cyc[0], hs_cyc[1]);
      else n_pass++;
    end
    n_total++;
    if (done_cyc.size() !== 1 || done_cyc[0] !== 4)
      $display("FAIL rst_fresh_done: got count %0d expected 1 at 4", done_cyc.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_speed();
    test_backpressure();
    test_wrap();
    test_empty_burst();
    test_ignored_start();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_rom_stream_reader
